// File: rtl/traffic_ctrl_nway.sv
// Round-robin N-approach traffic-light controller with pedestrian green
// extension, all-red clearance and a night flashing-yellow mode.
module traffic_ctrl_nway #(
    parameter int N_DIR      = 4,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 5,
    parameter int ALLRED_CYC = 2,
    parameter int PED_EXT    = 10,
    parameter int FLASH_HALF = 8,
    parameter int CNT_W      = 8,
    localparam int DIR_W     = $clog2(N_DIR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DIR-1:0] ped_req,
    input  logic             flash_mode,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] ped_walk,
    output logic [DIR_W-1:0] active_dir,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_GREEN     = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] C_GREEN_EXT = CNT_W'(GREEN_CYC + PED_EXT - 1);
    localparam logic [CNT_W-1:0] C_YELLOW    = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_ALLRED    = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] C_FLASH     = CNT_W'(FLASH_HALF - 1);
    localparam logic [DIR_W-1:0] C_LAST_DIR  = DIR_W'(N_DIR - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIR_W-1:0]   r_dir;
    logic [N_DIR-1:0]   r_pending;
    logic               r_ped_active;
    logic               r_flash_ph;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DIR_W-1:0]   w_dir_nxt;
    logic [DIR_W-1:0]   w_dir_inc;
    logic               w_ped_active_nxt;
    logic               w_flash_ph_nxt;
    logic [N_DIR-1:0]   w_clear;

    assign w_dir_inc = (r_dir == C_LAST_DIR) ? '0 : r_dir + DIR_W'(1);

    // State register: every phase register, plus the sticky request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_ALLRED;
            r_cnt        <= C_ALLRED;
            r_dir        <= C_LAST_DIR;
            r_pending    <= '0;
            r_ped_active <= 1'b0;
            r_flash_ph   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dir        <= w_dir_nxt;
            r_ped_active <= w_ped_active_nxt;
            r_flash_ph   <= w_flash_ph_nxt;
            // A request arriving on its own clearing edge survives to the next round.
            r_pending    <= (r_pending & ~w_clear) | ped_req;
        end
    end

    // Next-state: a phase ends on the cycle its counter reaches zero.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt - CNT_W'(1);
        w_dir_nxt        = r_dir;
        w_ped_active_nxt = r_ped_active;
        w_flash_ph_nxt   = r_flash_ph;
        w_clear          = '0;
        if (r_cnt == '0) begin
            case (r_state)
                S_ALLRED: begin
                    if (flash_mode) begin
                        w_state_nxt    = S_FLASH;
                        w_cnt_nxt      = C_FLASH;
                        w_flash_ph_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_GREEN;
                        w_dir_nxt   = w_dir_inc;
                        if (r_pending[w_dir_inc]) begin
                            w_cnt_nxt        = C_GREEN_EXT;
                            w_ped_active_nxt = 1'b1;
                            w_clear          = N_DIR'(1) << w_dir_inc;
                        end else begin
                            w_cnt_nxt        = C_GREEN;
                            w_ped_active_nxt = 1'b0;
                        end
                    end
                end
                S_GREEN: begin
                    w_state_nxt      = S_YELLOW;
                    w_cnt_nxt        = C_YELLOW;
                    w_ped_active_nxt = 1'b0;
                end
                S_YELLOW: begin
                    w_state_nxt = S_ALLRED;
                    w_cnt_nxt   = C_ALLRED;
                end
                S_FLASH: begin
                    if (!flash_mode) begin
                        w_state_nxt    = S_ALLRED;
                        w_cnt_nxt      = C_ALLRED;
                        w_flash_ph_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt      = C_FLASH;
                        w_flash_ph_nxt = ~r_flash_ph;
                    end
                end
                default: begin
                    w_state_nxt = S_ALLRED;
                    w_cnt_nxt   = C_ALLRED;
                end
            endcase
        end
    end

    // Lamp decode straight from registers, so outputs settle one edge after a decision.
    always_comb begin
        red      = '1;
        yellow   = '0;
        green    = '0;
        ped_walk = '0;
        case (r_state)
            S_GREEN: begin
                green[r_dir]    = 1'b1;
                red[r_dir]      = 1'b0;
                ped_walk[r_dir] = r_ped_active;
            end
            S_YELLOW: begin
                yellow[r_dir] = 1'b1;
                red[r_dir]    = 1'b0;
            end
            S_FLASH: begin
                red    = '0;
                yellow = {N_DIR{r_flash_ph}};
            end
            default: ;
        endcase
    end

    assign active_dir  = r_dir;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Bench for traffic_ctrl_nway: a phase-timeline reference model checked every
// cycle, a directed script with hand-computed pins, then randomized traffic.
module tb_traffic_ctrl_nway;

  localparam int N  = 3;
  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int A  = 1;
  localparam int P  = 3;
  localparam int FH = 2;
  localparam int CW = 8;

  localparam int PH_AR = 0;
  localparam int PH_G  = 1;
  localparam int PH_Y  = 2;
  localparam int PH_FL = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] ped_req = '0;
  logic flash_mode = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] red, yellow, green, ped_walk;
  logic [1:0]   active_dir;
  logic [1:0]   dbg_state;

  traffic_ctrl_nway #(
    .N_DIR(N), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A),
    .PED_EXT(P), .FLASH_HALF(FH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_mode(flash_mode),
    .red(red), .yellow(yellow), .green(green), .ped_walk(ped_walk),
    .active_dir(active_dir), .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model: phase kind, cycles elapsed in it, its length
  int m_ph, m_age, m_len, m_cur;
  bit [N-1:0] m_pend;
  bit m_walk, m_fph;

  task automatic model_reset();
    m_ph = PH_AR; m_age = 0; m_len = A; m_cur = N - 1;
    m_pend = '0; m_walk = 1'b0; m_fph = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] req, input logic fm);
    bit [N-1:0] clr;
    clr = '0;
    if (r) begin
      model_reset();
      return;
    end
    m_age++;
    if (m_age == m_len) begin
      m_age = 0;
      case (m_ph)
        PH_AR: begin
          if (fm) begin
            m_ph = PH_FL; m_len = FH; m_fph = 1'b1;
          end else begin
            m_cur = (m_cur + 1) % N;
            m_ph = PH_G;
            if (m_pend[m_cur]) begin
              m_len = G + P; m_walk = 1'b1; clr[m_cur] = 1'b1;
            end else begin
              m_len = G; m_walk = 1'b0;
            end
          end
        end
        PH_G: begin m_ph = PH_Y; m_len = Y; m_walk = 1'b0; end
        PH_Y: begin m_ph = PH_AR; m_len = A; end
        default: begin
          if (!fm) begin
            m_ph = PH_AR; m_len = A; m_fph = 1'b0;
          end else begin
            m_fph = !m_fph; m_len = FH;
          end
        end
      endcase
    end
    m_pend = (m_pend & ~clr) | req;
  endtask

  initial model_reset();
  always @(posedge clk) model_step(rst, ped_req, flash_mode);

  function automatic logic [N-1:0] exp_green();
    exp_green = '0;
    if (m_ph == PH_G) exp_green[m_cur] = 1'b1;
  endfunction

  function automatic logic [N-1:0] exp_yellow();
    exp_yellow = '0;
    if (m_ph == PH_Y) exp_yellow[m_cur] = 1'b1;
    if (m_ph == PH_FL) exp_yellow = {N{m_fph}};
  endfunction

  function automatic logic [N-1:0] exp_red();
    exp_red = '1;
    if (m_ph == PH_G || m_ph == PH_Y) exp_red[m_cur] = 1'b0;
    if (m_ph == PH_FL) exp_red = '0;
  endfunction

  function automatic logic [N-1:0] exp_walk();
    exp_walk = '0;
    if (m_ph == PH_G && m_walk) exp_walk[m_cur] = 1'b1;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic inv_check();
    bit ok;
    int lit;
    int nonred;
    ok = 1'b1;
    nonred = 0;
    if (red != '0) begin
      for (int i = 0; i < N; i++) begin
        lit = int'(red[i]) + int'(yellow[i]) + int'(green[i]);
        if (lit != 1) ok = 1'b0;
        if (!red[i]) nonred++;
      end
      if (nonred > 1) ok = 1'b0;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL invariant t=%0t actual r=%b y=%b g=%b expected one lamp each, <=1 non-red",
                 $time, red, yellow, green);
      end
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("red",        8'(red),        8'(exp_red()));
      check("yellow",     8'(yellow),     8'(exp_yellow()));
      check("green",      8'(green),      8'(exp_green()));
      check("ped_walk",   8'(ped_walk),   8'(exp_walk()));
      check("active_dir", 8'(active_dir), 8'(m_cur));
      inv_check();
    end
  end

  // green lamps for the first 22 cycles after release, no requests
  logic [2:0] pin_g [22] = '{
    3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000,
    3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000,
    3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000,
    3'b001
  };

  task automatic pin(input string name, input logic [N-1:0] dut_v,
                     input logic [N-1:0] mdl_v, input logic [N-1:0] lit);
    check({"pin_", name}, 8'(dut_v), 8'(lit));
    check({"model_", name}, 8'(mdl_v), 8'(lit));
  endtask

  task automatic pins(input int k);
    if (k <= 22) pin("green_seq", green, exp_green(), pin_g[k-1]);
    case (k)
      29, 35:  begin pin("green_ext1", green, exp_green(), 3'b010);
                     pin("walk_ext1", ped_walk, exp_walk(), 3'b010); end
      36:      begin pin("green_end1", green, exp_green(), 3'b000);
                     pin("yellow_1", yellow, exp_yellow(), 3'b010); end
      49:      pin("green_held0", green, exp_green(), 3'b001);
      50:      pin("yellow_held0", yellow, exp_yellow(), 3'b001);
      56:      begin pin("green_norm1", green, exp_green(), 3'b010);
                     pin("walk_norm1", ped_walk, exp_walk(), 3'b000); end
      57:      pin("yellow_norm1", yellow, exp_yellow(), 3'b010);
      67:      pin("walk_ext0", ped_walk, exp_walk(), 3'b001);
      73:      pin("green_ext0", green, exp_green(), 3'b001);
      74:      pin("yellow_ext0", yellow, exp_yellow(), 3'b001);
      91:      begin pin("flash_on_y", yellow, exp_yellow(), 3'b111);
                     pin("flash_on_r", red, exp_red(), 3'b000); end
      93:      begin pin("flash_off_y", yellow, exp_yellow(), 3'b000);
                     pin("flash_off_r", red, exp_red(), 3'b000);
                     pin("flash_off_g", green, exp_green(), 3'b000); end
      97:      pin("flash_exit_r", red, exp_red(), 3'b111);
      98:      pin("flash_resume_g", green, exp_green(), 3'b001);
      107:     pin("walk_pre_rst", ped_walk, exp_walk(), 3'b010);
      108:     begin pin("rst_mid_red", red, exp_red(), 3'b111);
                     pin("rst_mid_walk", ped_walk, exp_walk(), 3'b000);
                     check("pin_rst_mid_dir", 8'(active_dir), 8'd2); end
      109:     pin("rst_first_g", green, exp_green(), 3'b001);
      default: ;
    endcase
  endtask

  // driver
  initial begin
    rst = 1'b1;
    ped_req = '0;
    flash_mode = 1'b0;
    repeat (3) @(negedge clk);
    pin("reset_red", red, exp_red(), 3'b111);
    pin("reset_yellow", yellow, exp_yellow(), 3'b000);
    pin("reset_green", green, exp_green(), 3'b000);
    pin("reset_walk", ped_walk, exp_walk(), 3'b000);
    check("pin_reset_dir", 8'(active_dir), 8'd2);
    chk_en = 1'b1;
    rst = 1'b0;

    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      pins(k);
      ped_req = '0;
      if (k == 22) ped_req = 3'b010;
      if (k >= 46 && k <= 49) ped_req = 3'b001;
      if (k == 98) ped_req = 3'b010;
      flash_mode = (k >= 85 && k < 96);
      rst = (k == 107);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ped_req = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
      if ($urandom_range(0, 299) == 0) flash_mode = ~flash_mode;
      rst = ($urandom_range(0, 499) == 0);
    end

    rst = 1'b0;
    ped_req = '0;
    flash_mode = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
